// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter shared by fetch and data ports
module unified_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int TIMER_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic                owner_data;   // 1 = current transaction belongs to the data port
    logic [STREAK_W-1:0] streak;       // consecutive data grants made while fetch was waiting
    logic [TIMER_W-1:0]  timer;        // WAIT cycles elapsed without mem_ack

    // Fetch gets the next slot once data has won MAX_DATA_STREAK times in a row over it.
    logic fetch_turn;
    assign fetch_turn = if_req && (streak == STREAK_MAX);

    // Stores return zero read data; loads return what memory presents with its ack.
    logic [DATA_W-1:0] ack_data;
    assign ack_data = mem_we ? '0 : mem_rdata;

    // Arbitration FSM: grant in IDLE, hold the memory request in WAIT, pulse the ack in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            owner_data <= 1'b0;
            streak     <= '0;
            timer      <= '0;
            if_rdata   <= '0;
            if_ack     <= 1'b0;
            dm_rdata   <= '0;
            dm_ack     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dm_req && !fetch_turn) begin
                        mem_req    <= 1'b1;
                        mem_we     <= dm_we;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        owner_data <= 1'b1;
                        timer      <= '0;
                        state      <= S_WAIT;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (if_req) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        owner_data <= 1'b0;
                        timer      <= '0;
                        streak     <= '0;
                        state      <= S_WAIT;
                    end else begin
                        streak <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                        if (owner_data) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= ack_data;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Memory never answered: abandon the access and flag it permanently.
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= S_DONE;
                        if (owner_data) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                S_DONE: begin
                    if_ack   <= 1'b0;
                    dm_ack   <= 1'b0;
                    if_rdata <= '0;
                    dm_rdata <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
